// File: rtl/wieg_regelaar.sv
// Cradle rocking controller: adapts the rocking level to crying and stress feedback,
// winds down after sustained silence and drives the motor with a level-proportional PWM.
module wieg_regelaar #(
    parameter int VENSTER      = 16,
    parameter int DREMPEL      = 2,
    parameter int STIL         = 32,
    parameter int START_NIVEAU = 3
) (
    input  logic       clk,
    input  logic       r,
    input  logic       huilActief,
    input  logic       stressLaag,
    output logic [2:0] niveau,
    output logic       motorPwm,
    output logic [1:0] toestand,
    output logic       actief
);

    typedef enum logic [1:0] {
        RUST   = 2'd0,
        WIEGEN = 2'd1,
        AFBOUW = 2'd2
    } toestand_t;

    localparam logic [7:0] WIN_LAST = 8'(VENSTER - 1);
    localparam logic [7:0] STIL_W   = 8'(STIL);
    localparam logic [2:0] START_W  = 3'(START_NIVEAU);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [2:0] niv_omhoog(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    function automatic logic [2:0] niv_omlaag_min1(input logic [2:0] v);
        return (v <= 3'd1) ? 3'd1 : v - 3'd1;
    endfunction

    logic       s_huil_q, s_stress_q;
    toestand_t  state_q, state_d;
    logic [2:0] niveau_q, niveau_d;
    logic [7:0] win_q, win_d;
    logic [3:0] puls_q, puls_d;
    logic [7:0] stil_q, stil_d;
    logic [2:0] pwm_cnt_q;
    logic       motorPwm_q;
    logic       actief_q, actief_d;

    logic       win_end;
    logic [3:0] puls_eff;
    logic [7:0] stil_inc;
    logic       stil_klaar;

    // A pulse in the last window cycle is folded in before the window is judged
    assign win_end    = (win_q == WIN_LAST);
    assign puls_eff   = s_stress_q ? sat_inc4(puls_q) : puls_q;
    assign stil_inc   = sat_inc8(stil_q);
    assign stil_klaar = !s_huil_q && (stil_inc == STIL_W);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUST:    if (s_huil_q) state_d = WIEGEN;
            WIEGEN:  if (stil_klaar) state_d = AFBOUW;
            AFBOUW: begin
                if (s_huil_q)                         state_d = WIEGEN;
                else if (win_end && niveau_q == 3'd0) state_d = RUST;
            end
            default: state_d = RUST;
        endcase
    end

    always_comb begin
        niveau_d = niveau_q;
        win_d    = 8'd0;
        puls_d   = 4'd0;
        stil_d   = 8'd0;
        actief_d = (state_d != RUST);
        case (state_q)
            RUST: begin
                niveau_d = s_huil_q ? START_W : 3'd0;
            end
            WIEGEN: begin
                if (state_d == WIEGEN) begin
                    stil_d = s_huil_q ? 8'd0 : stil_inc;
                    if (win_end) begin
                        if (int'(puls_eff) >= DREMPEL) niveau_d = niv_omlaag_min1(niveau_q);
                        else if (puls_eff == 4'd0)     niveau_d = niv_omhoog(niveau_q);
                    end else begin
                        win_d  = win_q + 8'd1;
                        puls_d = puls_eff;
                    end
                end
            end
            AFBOUW: begin
                // Crying again outranks a coinciding window end
                if (state_d == WIEGEN) begin
                    niveau_d = (niveau_q == 3'd0) ? 3'd1 : niveau_q;
                end else if (state_d == RUST) begin
                    niveau_d = 3'd0;
                end else if (win_end) begin
                    niveau_d = niveau_q - 3'd1;
                end else begin
                    win_d = win_q + 8'd1;
                end
            end
            default: niveau_d = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            s_huil_q   <= 1'b0;
            s_stress_q <= 1'b0;
            state_q    <= RUST;
            niveau_q   <= 3'd0;
            win_q      <= 8'd0;
            puls_q     <= 4'd0;
            stil_q     <= 8'd0;
            pwm_cnt_q  <= 3'd0;
            motorPwm_q <= 1'b0;
            actief_q   <= 1'b0;
        end else begin
            s_huil_q   <= huilActief;
            s_stress_q <= stressLaag;
            state_q    <= state_d;
            niveau_q   <= niveau_d;
            win_q      <= win_d;
            puls_q     <= puls_d;
            stil_q     <= stil_d;
            pwm_cnt_q  <= pwm_cnt_q + 3'd1;
            motorPwm_q <= (pwm_cnt_q < niveau_q);
            actief_q   <= actief_d;
        end
    end

    assign niveau   = niveau_q;
    assign motorPwm = motorPwm_q;
    assign toestand = state_q;
    assign actief   = actief_q;

endmodule

// File: tb/tb_wieg_regelaar.sv
// Scoreboarded bench for wieg_regelaar: a behavioural model predicts every cycle's
// outputs into a queue which an independent monitor drains against the DUT.
module tb_wieg_regelaar;

    localparam int VENSTER      = 16;
    localparam int DREMPEL      = 2;
    localparam int STIL         = 32;
    localparam int START_NIVEAU = 3;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic       huilActief = 1'b0;
    logic       stressLaag = 1'b0;
    logic [2:0] niveau;
    logic       motorPwm;
    logic [1:0] toestand;
    logic       actief;

    wieg_regelaar #(
        .VENSTER(VENSTER), .DREMPEL(DREMPEL), .STIL(STIL), .START_NIVEAU(START_NIVEAU)
    ) dut (
        .clk(clk), .r(r), .huilActief(huilActief), .stressLaag(stressLaag),
        .niveau(niveau), .motorPwm(motorPwm), .toestand(toestand), .actief(actief)
    );

    always #5 clk = ~clk;

    typedef struct {
        int niv;
        int st;
        int act;
        int pwm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: mode 0 idle, 1 rocking, 2 winding down
    int m_mode, m_lvl, m_win, m_pulses, m_quiet, m_phase, m_pwm, m_hreg, m_sreg;

    task automatic model_step(input bit rr, input bit h, input bit s);
        exp_t e;
        int sh, ss;
        if (rr) begin
            m_mode = 0; m_lvl = 0; m_win = 0; m_pulses = 0; m_quiet = 0;
            m_phase = 0; m_pwm = 0; m_hreg = 0; m_sreg = 0;
        end else begin
            sh = m_hreg;
            ss = m_sreg;
            m_pwm   = (m_phase < m_lvl) ? 1 : 0;
            m_phase = (m_phase + 1) % 8;
            if (m_mode == 0) begin
                if (sh == 1) begin
                    m_mode = 1; m_lvl = START_NIVEAU; m_win = 0; m_pulses = 0; m_quiet = 0;
                end
            end else if (m_mode == 1) begin
                m_quiet = (sh == 1) ? 0 : ((m_quiet < 255) ? m_quiet + 1 : 255);
                if (sh == 0 && m_quiet == STIL) begin
                    m_mode = 2; m_win = 0; m_pulses = 0;
                end else begin
                    if (ss == 1 && m_pulses < 15) m_pulses++;
                    if (m_win == VENSTER - 1) begin
                        if (m_pulses >= DREMPEL)  m_lvl = (m_lvl > 1) ? m_lvl - 1 : 1;
                        else if (m_pulses == 0)   m_lvl = (m_lvl < 7) ? m_lvl + 1 : 7;
                        m_win = 0; m_pulses = 0;
                    end else begin
                        m_win++;
                    end
                end
            end else begin
                if (sh == 1) begin
                    m_mode = 1; m_lvl = (m_lvl < 1) ? 1 : m_lvl;
                    m_win = 0; m_pulses = 0; m_quiet = 0;
                end else if (m_win == VENSTER - 1) begin
                    if (m_lvl == 0) m_mode = 0;
                    else            m_lvl--;
                    m_win = 0;
                end else begin
                    m_win++;
                end
            end
            m_hreg = h;
            m_sreg = s;
        end
        e.niv = m_lvl; e.st = m_mode; e.act = (m_mode != 0) ? 1 : 0; e.pwm = m_pwm;
        sb.push_back(e);
    endtask

    task automatic drive(input bit rr, input bit h, input bit s);
        @(negedge clk);
        r = rr; huilActief = h; stressLaag = s;
        model_step(rr, h, s);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Monitor: each edge the DUT presents a new output set
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("niveau",   int'(niveau),   e.niv);
                chk("toestand", int'(toestand), e.st);
                chk("actief",   int'(actief),   e.act);
                chk("motorPwm", int'(motorPwm), e.pwm);
            end
        end
    end

    initial begin
        int seg, h;
        repeat (3) drive(1, 0, 0);
        repeat (4) drive(0, 0, 0);

        // Ramp from start level to the ceiling, stopping at level 5 for the pulse windows
        for (int i = 0; i < 200 && !(m_mode == 1 && m_lvl == 5 && m_win == 0); i++) drive(0, 1, 0);
        for (int i = 0; i < VENSTER; i++) drive(0, 1, (m_win == 3 || m_win == VENSTER - 2));
        for (int i = 0; i < 2 * VENSTER; i++) drive(0, 1, (m_win == 5));
        for (int i = 0; i < 200 && m_lvl != 7; i++) drive(0, 1, 0);
        repeat (40) drive(0, 1, 0);

        // Constant stress drives the level to the floor and keeps it there
        repeat (10 * VENSTER) drive(0, 1, 1);

        // Back to level 3, then silence into wind-down; cry exactly at the empty window end
        for (int i = 0; i < 200 && m_lvl != 3; i++) drive(0, 1, 0);
        for (int i = 0; i < 400 && !(m_mode == 2 && m_lvl == 0 && m_win == VENSTER - 2); i++)
            drive(0, 0, 0);
        drive(0, 1, 0);
        repeat (6) drive(0, 1, 0);
        for (int i = 0; i < 400 && m_mode != 0; i++) drive(0, 0, 0);
        repeat (20) drive(0, 0, 0);

        // Reset while rocking at level 6, then confirm it stays idle until crying resumes
        for (int i = 0; i < 300 && !(m_mode == 1 && m_lvl == 6); i++) drive(0, 1, 0);
        repeat (16) drive(0, 1, 0);
        drive(1, 1, 0);
        repeat (12) drive(0, 0, 0);
        repeat (8) drive(0, 1, 0);

        // Randomised crying segments with sparse stress and rare resets
        for (int k = 0; k < 60; k++) begin
            seg = $urandom_range(1, 80);
            h = $urandom_range(0, 1);
            for (int i = 0; i < seg; i++)
                drive(($urandom_range(0, 499) == 0), h[0], ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wieg_regelaar.md
WIEG_REGELAAR -- requirements
Module: wieg_regelaar

Interface
REQ-001 Parameter VENSTER, default 16: evaluation window length in clk cycles (range 2..255).
REQ-002 Parameter DREMPEL, default 2: stressLaag pulse count per window at or above which the level steps down.
REQ-003 Parameter STIL, default 32: consecutive cycles of huilActief low that start wind-down.
REQ-004 Parameter START_NIVEAU, default 3: rocking level loaded on start (1..7).
REQ-005 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-006 Port r, input, 1: reset, synchronous and active-high.
REQ-007 Port huilActief, input, 1: level, high while the baby cries.
REQ-008 Port stressLaag, input, 1: stress-decrease indication from the deltaStress stage, sampled at the rising clk edge.
REQ-009 Port niveau, output, 3: current rocking level 0..7, registered.
REQ-010 Port motorPwm, output, 1: registered PWM drive for the cradle motor.
REQ-011 Port toestand, output, 2: FSM state code; RUST=0, WIEGEN=1, AFBOUW=2.
REQ-012 Port actief, output, 1: high when toestand != RUST, registered.

Function
REQ-013 huilActief and stressLaag SHALL each pass through one input register; every reference below to them means the registered copies (s_huil, s_stress).
REQ-014 In RUST: niveau=0. When s_huil=1, the FSM SHALL go to WIEGEN and load niveau=START_NIVEAU on the same edge.
REQ-015 Window counter SHALL run 0..VENSTER-1 in WIEGEN and AFBOUW, wrap to 0, and clear on every state entry.
REQ-016 Pulse counter (4 bits, saturating at 15) SHALL count cycles with s_stress=1 in WIEGEN; it clears at window end.
REQ-017 A pulse in the last window cycle SHALL count toward the ending window.
REQ-018 At window end in WIEGEN: count >= DREMPEL -> niveau-1 (floor 1); count = 0 -> niveau+1 (ceiling 7); otherwise hold.
REQ-019 Silence counter (8 bits, saturating) SHALL increment each cycle s_huil=0 in WIEGEN and clear when s_huil=1.
REQ-020 When the silence counter reaches STIL, the FSM SHALL go WIEGEN->AFBOUW on that edge; niveau is unchanged.
REQ-021 In AFBOUW, niveau SHALL decrement by 1 at each window end; s_stress is ignored.
REQ-022 In AFBOUW with niveau=0 at a window end, the FSM SHALL go to RUST.
REQ-023 s_huil=1 in AFBOUW SHALL take priority over a window end and go to WIEGEN, with niveau = max(niveau, 1), counters cleared.
REQ-024 PWM: a free-running 3-bit counter SHALL run in every state; motorPwm is registered from (counter < niveau), giving duty niveau/8. niveau=0 SHALL give a constant 0.
REQ-025 Latency: a change of niveau SHALL appear on motorPwm no later than 9 cycles afterwards.
REQ-026 toestand and actief SHALL update on the same edge as the state register.

Reset
REQ-027 With r=1 at a rising edge, the block SHALL clear every register: state RUST, niveau=0, motorPwm=0, actief=0, toestand=0, all counters and input registers 0.
REQ-028 Reset SHALL apply in any state and override every other event in the same cycle; after r falls the block resumes only on the next s_huil=1.

Verification
REQ-029 Reset, then huilActief=1 held, stressLaag=0 -> toestand=1 and niveau=3 two edges after huilActief rises; niveau=4 after 16 more cycles; 5, 6, 7 after each further 16 cycles; then held at 7.
REQ-030 In WIEGEN at niveau=5, two single-cycle stressLaag pulses in one window, one of them in the last window cycle -> niveau=4 at window end; one pulse per window -> niveau held at 4.
REQ-031 At niveau=1, stressLaag pulses every cycle -> niveau stays 1 and pulse count saturates at 15 without wrap.
REQ-032 niveau=3, huilActief dropped -> AFBOUW after 32 cycles; niveau 2, 1, 0 at successive 16-cycle window ends; RUST at the next window end; motorPwm constant 0 once niveau=0.
REQ-033 In AFBOUW at niveau=0, huilActief rises in the same cycle as a window end -> WIEGEN with niveau=1, not RUST.
REQ-034 In WIEGEN at niveau=6, pulse r high for one cycle -> all outputs 0 at the next edge; no restart until huilActief rises; motorPwm duty measured at 6/8 before reset.
